reorder_buffer: RTL and testbench

Circular reorder buffer that sits directly upstream of the architectural register file and is the only source of its write port. Dispatch allocates entries in program order, functional units complete entries out of order over a single common data bus (CDB), and the buffer commits at most one entry per cycle, in order, by driving the register file's write-enable, address and data. Two tag-indexed lookup ports let dispatch forward completed-but-uncommitted results.

---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob_ptr.sv | 18 +
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer and its helpers.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_ADDR  = 5;
  localparam int ROB_WIDTH = 32;

  function automatic int tag_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 we;
    logic [ROB_ADDR-1:0]  rd;
    logic [ROB_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer; wraps for free because the ring size is a power of two.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit ring: program-order allocate, out-of-order CDB completion,
// single retire per cycle driving the register file write port.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int ADDR  = ROB_ADDR,
  parameter int WIDTH = ROB_WIDTH,
  parameter int TAGW  = tag_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [ADDR-1:0]  alloc_rd,
  input  logic             alloc_we,
  output logic             alloc_ready,
  output logic [TAGW-1:0]  alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tag,
  input  logic [WIDTH-1:0] cdb_data,
  input  logic [TAGW-1:0]  look_tag1,
  input  logic [TAGW-1:0]  look_tag2,
  output logic             look_ready1,
  output logic             look_ready2,
  output logic [WIDTH-1:0] look_data1,
  output logic [WIDTH-1:0] look_data2,
  output logic             rf_reg_write,
  output logic [ADDR-1:0]  rf_write_reg,
  output logic [WIDTH-1:0] rf_write_data,
  output logic [TAGW-1:0]  commit_tag,
  output logic             commit_fire,
  output logic             empty,
  output logic             full
);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             we;
    logic [ADDR-1:0]  rd;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam logic [TAGW:0] CAP = (TAGW+1)'(DEPTH);

  entry_t          ent [DEPTH];
  entry_t          head_e;
  logic [TAGW-1:0] head, tail;
  logic [TAGW:0]   count;
  logic            alloc_fire;

  rob_ptr #(.W(TAGW)) u_head (.clk(clk), .rst(rst), .clr(flush), .inc(commit_fire), .ptr(head));
  rob_ptr #(.W(TAGW)) u_tail (.clk(clk), .rst(rst), .clr(flush), .inc(alloc_fire),  .ptr(tail));

  // Status comes only from the registered count, so a same-cycle commit frees nothing yet.
  assign alloc_ready = (count < CAP);
  assign full        = (count == CAP);
  assign empty       = (count == '0);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  assign head_e      = ent[head];
  assign commit_fire = head_e.valid && head_e.done && !flush;

  always_comb begin
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    commit_tag    = '0;
    if (commit_fire) begin
      rf_reg_write  = head_e.we && (head_e.rd != '0);
      rf_write_reg  = head_e.rd;
      rf_write_data = head_e.data;
      commit_tag    = head;
    end
  end

  assign look_ready1 = ent[look_tag1].valid && ent[look_tag1].done;
  assign look_ready2 = ent[look_tag2].valid && ent[look_tag2].done;
  assign look_data1  = ent[look_tag1].data;
  assign look_data2  = ent[look_tag2].data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (flush) count <= '0;
    else            count <= count + {{TAGW{1'b0}}, alloc_fire} - {{TAGW{1'b0}}, commit_fire};
  end

  // Alloc, CDB and commit never target the same live entry in one cycle,
  // so the update order below only matters for ignored/overridden cases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && cdb_tag == TAGW'(i) && ent[i].valid) begin
          ent[i].done <= 1'b1;
          ent[i].data <= cdb_data;
        end
        if (alloc_fire && tail == TAGW'(i)) begin
          ent[i].valid <= 1'b1;
          ent[i].done  <= 1'b0;
          ent[i].we    <= alloc_we;
          ent[i].rd    <= alloc_rd;
        end
        if (commit_fire && head == TAGW'(i)) begin
          ent[i].valid <= 1'b0;
          ent[i].done  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a program-order queue model predicts each
// cycle's status and retirement, and a monitor compares the DUT against it.
module tb_reorder_buffer;

  localparam int D = 16;

  logic        clk = 0, rst = 1, flush = 0;
  logic        alloc_valid = 0, alloc_we = 0;
  logic [4:0]  alloc_rd = 0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid = 0;
  logic [3:0]  cdb_tag = 0;
  logic [31:0] cdb_data = 0;
  logic [3:0]  look_tag1 = 0, look_tag2 = 0;
  logic        look_ready1, look_ready2;
  logic [31:0] look_data1, look_data2;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [3:0]  commit_tag;
  logic        commit_fire, empty, full;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_we(alloc_we),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .look_tag1(look_tag1), .look_tag2(look_tag2),
    .look_ready1(look_ready1), .look_ready2(look_ready2),
    .look_data1(look_data1), .look_data2(look_data2),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .commit_tag(commit_tag), .commit_fire(commit_fire), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Model: live instructions in program order; head is element 0.
  typedef struct { int tag; bit we; int rd; bit done; logic [31:0] data; } ment_t;
  typedef struct { bit fire; bit ar; bit fl; bit em; int atag;
                   bit lr1, lr2; logic [31:0] ld1, ld2; } cyc_t;
  typedef struct { int tag; bit rwe; int rd; logic [31:0] data; } com_t;

  ment_t mq[$];
  cyc_t  cyc_q[$];
  com_t  com_q[$];
  int    next_tag = 0;
  int    n_tests = 0, n_fail = 0;
  int    lk1 = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input int tag);
    for (int k = 0; k < mq.size(); k++) if (mq[k].tag == tag) return k;
    return -1;
  endfunction

  task automatic step(input bit av, input int rd, input bit we,
                      input bit cv, input int ctag, input logic [31:0] cd, input bit fl);
    cyc_t e;
    com_t c;
    int   cnt, idx;
    @(negedge clk);
    alloc_valid = av; alloc_rd = rd[4:0]; alloc_we = we;
    cdb_valid = cv; cdb_tag = ctag[3:0]; cdb_data = cd; flush = fl;
    look_tag1 = (lk1 >= 0) ? lk1[3:0] : 4'($urandom_range(0, D-1));
    look_tag2 = 4'($urandom_range(0, D-1));
    cnt    = mq.size();
    e.ar   = cnt < D;
    e.fl   = cnt == D;
    e.em   = cnt == 0;
    e.atag = next_tag;
    e.fire = !fl && cnt > 0 && mq[0].done;
    idx = find(int'(look_tag1));
    e.lr1 = idx >= 0 && mq[idx].done;
    e.ld1 = e.lr1 ? mq[idx].data : 32'h0;
    idx = find(int'(look_tag2));
    e.lr2 = idx >= 0 && mq[idx].done;
    e.ld2 = e.lr2 ? mq[idx].data : 32'h0;
    if (e.fire) begin
      c.tag = mq[0].tag; c.rwe = mq[0].we && mq[0].rd != 0;
      c.rd = mq[0].rd; c.data = mq[0].data;
      com_q.push_back(c);
    end
    cyc_q.push_back(e);
    if (fl) begin
      mq.delete();
      next_tag = 0;
    end else begin
      if (cv) begin
        idx = find(ctag);
        if (idx >= 0) begin mq[idx].done = 1; mq[idx].data = cd; end
      end
      if (e.fire) void'(mq.pop_front());
      if (av && cnt < D) begin
        mq.push_back('{tag: next_tag, we: we, rd: rd, done: 0, data: 32'h0});
        next_tag = (next_tag + 1) % D;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares once per driven cycle, pops the commit scoreboard on each retire.
  initial begin
    cyc_t e;
    com_t c;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("alloc_ready", alloc_ready, e.ar);
        chk("full", full, e.fl);
        chk("empty", empty, e.em);
        chk("alloc_tag", alloc_tag, e.atag);
        chk("look_ready1", look_ready1, e.lr1);
        chk("look_ready2", look_ready2, e.lr2);
        if (e.lr1) chk("look_data1", look_data1, e.ld1);
        if (e.lr2) chk("look_data2", look_data2, e.ld2);
        chk("commit_fire", commit_fire, e.fire);
        if (commit_fire && com_q.size() > 0) begin
          c = com_q.pop_front();
          chk("commit_tag", commit_tag, c.tag);
          chk("rf_reg_write", rf_reg_write, c.rwe);
          chk("rf_write_reg", rf_write_reg, c.rd);
          chk("rf_write_data", rf_write_data, c.data);
        end else begin
          if (e.fire && com_q.size() > 0) void'(com_q.pop_front());
          chk("rf_idle", {rf_reg_write, rf_write_reg, rf_write_data}, 38'h0);
        end
      end
    end
  end

  initial begin
    int t, hd;
    // Power-on reset
    #12;
    chk("rst_empty", empty, 1'b1);
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_alloc_tag", alloc_tag, 4'd0);
    chk("rst_commit_fire", commit_fire, 1'b0);
    @(negedge clk); rst = 0;
    idle(2);

    // Five live entries, then an asynchronous reset mid-cycle
    for (int k = 0; k < 5; k++) step(1, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h1111, 0);
    @(negedge clk);
    #3;
    alloc_valid = 0; cdb_valid = 0; flush = 0;
    rst = 1;
    #1;
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_alloc_ready", alloc_ready, 1'b1);
    chk("midrst_alloc_tag", alloc_tag, 4'd0);
    chk("midrst_rf_reg_write", rf_reg_write, 1'b0);
    chk("midrst_commit_fire", commit_fire, 1'b0);
    mq.delete(); next_tag = 0;
    @(negedge clk); rst = 0;
    idle(3);

    // Basic retire after two cycles
    for (int k = 0; k < 5; k++) step(1, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    idle(2);

    // Out-of-order completion, in-order retire
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 7, 1, 0, 0, 0, 0);
    step(1, 8, 1, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 32'hC2, 0);
    step(0, 0, 0, 1, 1, 32'hC1, 0);
    step(0, 0, 0, 1, 0, 32'hC0, 0);
    idle(4);

    // Fill to capacity, reject extra, then wrap tag 0
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < D + 1; k++) step(1, k % 32, 1, 0, 0, 0, 0);
    step(1, 3, 1, 1, 0, 32'hA0, 0);
    step(1, 4, 1, 0, 0, 0, 0);
    step(1, 6, 1, 0, 0, 0, 0);
    for (int k = 0; k < D; k++) begin
      t = (k + 1) % D;
      step(0, 0, 0, 1, t, 32'hB000 + k, 0);
    end
    idle(D + 2);

    // Register 0 and non-writing instructions still retire
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, next_tag - 2 < 0 ? next_tag + D - 2 : next_tag - 2, 32'h5A5A, 0);
    step(0, 0, 0, 1, next_tag - 1 < 0 ? next_tag + D - 1 : next_tag - 1, 32'hA5A5, 0);
    idle(3);

    // Flush beats alloc, CDB and a committable head
    step(1, 10, 1, 0, 0, 0, 0);
    step(1, 11, 1, 0, 0, 0, 0);
    hd = mq[0].tag;
    step(0, 0, 0, 1, hd, 32'h77, 0);
    step(1, 13, 1, 1, (hd + 1) % D, 32'h88, 1);
    for (int k = 0; k < D; k++) begin
      lk1 = k;
      step(0, 0, 0, 0, 0, 0, 0);
    end
    lk1 = -1;

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      bit av, cv, fl;
      int ct;
      av = $urandom_range(0, 99) < 60;
      cv = $urandom_range(0, 99) < 55;
      fl = $urandom_range(0, 199) == 0;
      if (mq.size() > 0 && $urandom_range(0, 9) != 0)
        ct = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ct = $urandom_range(0, D - 1);
      step(av, $urandom_range(0, 31), $urandom_range(0, 3) != 0, cv, ct, $urandom, fl);
    end
    idle(4);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
